// File: rtl/instruction_decode.sv
// MIPS ID stage: register file, decode, ID-resolved jumps/branches, hazard detection, ID/EX register.
// Optional macro ID_REGFILE_BYPASS_EN forwards a same-cycle write-back to the register read ports.
module instruction_decode #(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_INSTR = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned NB_INM_I = 16,
  parameter int unsigned NB_INM_J = 26
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_INSTR-1:0] i_ir,
  input  logic [NB_REG-1:0]   i_pc,
  input  logic                i_wb_we,
  input  logic [NB_ADDR-1:0]  i_wb_addr,
  input  logic [NB_REG-1:0]   i_wb_data,
  input  logic                i_mem_reg_we,
  input  logic [NB_ADDR-1:0]  i_mem_wb_addr,
  output logic [NB_INM_I-1:0] o_inm_i,
  output logic [NB_INM_J-1:0] o_inm_j,
  output logic [NB_REG-1:0]   o_rs,
  output logic                o_jump_inm,
  output logic                o_jump_rs,
  output logic                o_branch,
  output logic                o_hazard,
  output logic                o_nop_reg,
  output logic [NB_REG-1:0]   o_ex_rs_data,
  output logic [NB_REG-1:0]   o_ex_rt_data,
  output logic [NB_REG-1:0]   o_ex_inm,
  output logic [NB_REG-1:0]   o_ex_pc,
  output logic [5:0]          o_ex_opcode,
  output logic [5:0]          o_ex_funct,
  output logic [4:0]          o_ex_shamt,
  output logic [NB_ADDR-1:0]  o_ex_wb_addr,
  output logic                o_ex_reg_we,
  output logic                o_ex_mem_read,
  output logic                o_ex_mem_write
);

  localparam int unsigned NUM_REGS = 1 << NB_ADDR;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef struct packed {
    logic [NB_REG-1:0]  rs_data;
    logic [NB_REG-1:0]  rt_data;
    logic [NB_REG-1:0]  inm;
    logic [NB_REG-1:0]  pc;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic [NB_ADDR-1:0] wb_addr;
    logic               reg_we;
    logic               mem_read;
    logic               mem_write;
  } idex_t;

  logic [NB_REG-1:0]  rf_q [NUM_REGS];
  idex_t              ex_q, ex_d, dec;
  logic               nop_q, nop_d;

  logic [5:0]         op, funct;
  logic [NB_ADDR-1:0] rs_a, rt_a, rd_a, dest;
  logic [NB_REG-1:0]  rs_val, rt_val;
  logic               is_jr, is_jalr, is_beq, is_bne, is_load, is_store, reads_rt;
  logic               load_use, ctrl_dep, wb_dep, squash;

  assign op      = i_ir[31:26];
  assign rs_a    = i_ir[25:21];
  assign rt_a    = i_ir[20:16];
  assign rd_a    = i_ir[15:11];
  assign funct   = i_ir[5:0];
  assign o_inm_i = i_ir[NB_INM_I-1:0];
  assign o_inm_j = i_ir[NB_INM_J-1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (i_wb_we && (i_wb_addr != '0)) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

`ifdef ID_REGFILE_BYPASS_EN
  always_comb begin
    rs_val = rf_q[rs_a];
    rt_val = rf_q[rt_a];
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rs_a)) rs_val = i_wb_data;
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rt_a)) rt_val = i_wb_data;
  end
`else
  assign rs_val = rf_q[rs_a];
  assign rt_val = rf_q[rt_a];
`endif
  assign o_rs = rs_val;

  function automatic logic src_hit(input logic [NB_ADDR-1:0] a, rs, rt, input logic use_rt);
    return (a != '0) && ((a == rs) || (use_rt && (a == rt)));
  endfunction

  always_comb begin
    is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    is_jalr  = (op == OP_RTYPE) && (funct == FN_JALR);
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_load  = (op[5:3] == 3'b100);
    is_store = (op[5:3] == 3'b101);
    reads_rt = (op == OP_RTYPE) || is_beq || is_bne || is_store;

    dest = '0;
    if (op == OP_RTYPE)                      dest = rd_a;
    else if (op == OP_JAL)                   dest = NB_ADDR'(31);
    else if ((op[5:3] == 3'b001) || is_load) dest = rt_a;

    dec           = '0;
    dec.rs_data   = rs_val;
    dec.rt_data   = rt_val;
    dec.inm       = (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                  ? {{(NB_REG-NB_INM_I){1'b0}}, o_inm_i}
                  : {{(NB_REG-NB_INM_I){o_inm_i[NB_INM_I-1]}}, o_inm_i};
    dec.pc        = i_pc;
    dec.opcode    = op;
    dec.funct     = funct;
    dec.shamt     = i_ir[10:6];
    dec.wb_addr   = dest;
    dec.reg_we    = (dest != '0) && !(is_jr || is_beq || is_bne || is_store || (op == OP_J));
    dec.mem_read  = is_load;
    dec.mem_write = is_store;
  end

  // Branches and register jumps resolve here, so any in-flight producer of their sources must drain first.
  always_comb begin
    load_use = o_ex_mem_read && src_hit(o_ex_wb_addr, rs_a, rt_a, reads_rt);
    ctrl_dep = (is_beq || is_bne || is_jr || is_jalr) &&
               ((o_ex_reg_we && src_hit(o_ex_wb_addr, rs_a, rt_a, reads_rt)) ||
                (i_mem_reg_we && src_hit(i_mem_wb_addr, rs_a, rt_a, reads_rt)));
`ifdef ID_REGFILE_BYPASS_EN
    wb_dep   = 1'b0;
`else
    wb_dep   = i_wb_we && src_hit(i_wb_addr, rs_a, rt_a, reads_rt);
`endif
    o_hazard = load_use || ctrl_dep || wb_dep;
    squash   = o_hazard || nop_q;

    o_jump_inm = !squash && ((op == OP_J) || (op == OP_JAL));
    o_jump_rs  = !squash && (is_jr || is_jalr);
    o_branch   = !squash && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));

    nop_d = o_jump_inm || o_jump_rs || o_branch;
    ex_d  = squash ? '0 : dec;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      nop_q <= 1'b0;
      ex_q  <= '0;
    end else if (i_valid) begin
      nop_q <= nop_d;
      ex_q  <= ex_d;
    end
  end

  assign o_nop_reg      = nop_q;
  assign o_ex_rs_data   = ex_q.rs_data;
  assign o_ex_rt_data   = ex_q.rt_data;
  assign o_ex_inm       = ex_q.inm;
  assign o_ex_pc        = ex_q.pc;
  assign o_ex_opcode    = ex_q.opcode;
  assign o_ex_funct     = ex_q.funct;
  assign o_ex_shamt     = ex_q.shamt;
  assign o_ex_wb_addr   = ex_q.wb_addr;
  assign o_ex_reg_we    = ex_q.reg_we;
  assign o_ex_mem_read  = ex_q.mem_read;
  assign o_ex_mem_write = ex_q.mem_write;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed pipeline scenarios plus randomized traffic against a behavioural model.
module tb_instruction_decode;

  logic        i_clock = 1'b0;
  logic        i_reset, i_valid, i_wb_we, i_mem_reg_we;
  logic [31:0] i_ir, i_pc, i_wb_data;
  logic [4:0]  i_wb_addr, i_mem_wb_addr;
  logic [15:0] o_inm_i;
  logic [25:0] o_inm_j;
  logic [31:0] o_rs, o_ex_rs_data, o_ex_rt_data, o_ex_inm, o_ex_pc;
  logic        o_jump_inm, o_jump_rs, o_branch, o_hazard, o_nop_reg;
  logic [5:0]  o_ex_opcode, o_ex_funct;
  logic [4:0]  o_ex_shamt, o_ex_wb_addr;
  logic        o_ex_reg_we, o_ex_mem_read, o_ex_mem_write;

  always #5 i_clock = ~i_clock;

  instruction_decode #(.NB_REG(32), .NB_INSTR(32), .NB_ADDR(5), .NB_INM_I(16), .NB_INM_J(26)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_ir(i_ir), .i_pc(i_pc),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_mem_reg_we(i_mem_reg_we), .i_mem_wb_addr(i_mem_wb_addr),
    .o_inm_i(o_inm_i), .o_inm_j(o_inm_j), .o_rs(o_rs),
    .o_jump_inm(o_jump_inm), .o_jump_rs(o_jump_rs), .o_branch(o_branch),
    .o_hazard(o_hazard), .o_nop_reg(o_nop_reg),
    .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data), .o_ex_inm(o_ex_inm),
    .o_ex_pc(o_ex_pc), .o_ex_opcode(o_ex_opcode), .o_ex_funct(o_ex_funct),
    .o_ex_shamt(o_ex_shamt), .o_ex_wb_addr(o_ex_wb_addr), .o_ex_reg_we(o_ex_reg_we),
    .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_write(o_ex_mem_write)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] rs_data, rt_data, inm, pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, wb_addr;
    logic        reg_we, mem_read, mem_write;
  } idex_t;

  logic [31:0] rf_m [32];
  idex_t       ex_m, ex_next;
  logic        nop_m, nop_next;
  logic        e_hazard, e_jinm, e_jrs, e_br;
  logic [31:0] e_rs;

  logic        ob_hazard, ob_branch, ob_jinm, ob_jrs;
  logic [31:0] ob_rs, ob_inm_i;
  logic [31:0] tb_pc = 32'h0000_0010;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    ex_m  = '0;
    nop_m = 1'b0;
  endtask

  function automatic logic [31:0] rd_m(input int a);
    if (a == 0) return 32'h0;
`ifdef ID_REGFILE_BYPASS_EN
    if (i_wb_we && (a == int'(i_wb_addr))) return i_wb_data;
`endif
    return rf_m[a];
  endfunction

  function automatic logic uses(input int a, input int rs, input int rt, input logic rt_used);
    return (a != 0) && ((a == rs) || (rt_used && (a == rt)));
  endfunction

  task automatic model_eval();
    int op, rs, rt, rd, fn, dest;
    logic rt_used, jr, jalr, ctrl, we, squash;
    logic [15:0] imm;
    op = int'(i_ir[31:26]); rs = int'(i_ir[25:21]); rt = int'(i_ir[20:16]);
    rd = int'(i_ir[15:11]); fn = int'(i_ir[5:0]);   imm = i_ir[15:0];
    jr = (op == 0) && (fn == 8);
    jalr = (op == 0) && (fn == 9);
    if (op == 0) dest = rd;
    else if (op == 3) dest = 31;
    else if ((op >= 8 && op <= 15) || (op / 8 == 4)) dest = rt;
    else dest = 0;
    rt_used = (op == 0) || (op == 4) || (op == 5) || (op / 8 == 5);
    we = (dest != 0) && !(jr || op == 2 || op == 4 || op == 5 || op / 8 == 5);
    ctrl = jr || jalr || op == 4 || op == 5;
    e_hazard = (ex_m.mem_read && uses(int'(ex_m.wb_addr), rs, rt, rt_used)) ||
               (ctrl && ex_m.reg_we && uses(int'(ex_m.wb_addr), rs, rt, rt_used)) ||
               (ctrl && i_mem_reg_we && uses(int'(i_mem_wb_addr), rs, rt, rt_used));
`ifndef ID_REGFILE_BYPASS_EN
    e_hazard = e_hazard || (i_wb_we && uses(int'(i_wb_addr), rs, rt, rt_used));
`endif
    squash = e_hazard || nop_m;
    e_jinm = !squash && (op == 2 || op == 3);
    e_jrs  = !squash && (jr || jalr);
    e_br   = !squash && ((op == 4 && rd_m(rs) == rd_m(rt)) || (op == 5 && rd_m(rs) != rd_m(rt)));
    e_rs   = rd_m(rs);
    nop_next = e_jinm || e_jrs || e_br;
    ex_next = '0;
    if (!squash) begin
      ex_next.rs_data   = rd_m(rs);
      ex_next.rt_data   = rd_m(rt);
      ex_next.inm       = (op == 12 || op == 13 || op == 14) ? {16'h0, imm} : {{16{imm[15]}}, imm};
      ex_next.pc        = i_pc;
      ex_next.opcode    = i_ir[31:26];
      ex_next.funct     = i_ir[5:0];
      ex_next.shamt     = i_ir[10:6];
      ex_next.wb_addr   = dest[4:0];
      ex_next.reg_we    = we;
      ex_next.mem_read  = (op / 8 == 4);
      ex_next.mem_write = (op / 8 == 5);
    end
  endtask

  task automatic model_commit();
    if (i_valid) begin
      ex_m  = ex_next;
      nop_m = nop_next;
    end
    if (i_wb_we && i_wb_addr != 5'd0) rf_m[i_wb_addr] = i_wb_data;
  endtask

  task automatic check_regs();
    check("ex_rs_data", o_ex_rs_data, ex_m.rs_data);
    check("ex_rt_data", o_ex_rt_data, ex_m.rt_data);
    check("ex_inm", o_ex_inm, ex_m.inm);
    check("ex_pc", o_ex_pc, ex_m.pc);
    check("ex_opcode", 32'(o_ex_opcode), 32'(ex_m.opcode));
    check("ex_funct", 32'(o_ex_funct), 32'(ex_m.funct));
    check("ex_shamt", 32'(o_ex_shamt), 32'(ex_m.shamt));
    check("ex_wb_addr", 32'(o_ex_wb_addr), 32'(ex_m.wb_addr));
    check("ex_ctl", {29'h0, o_ex_reg_we, o_ex_mem_read, o_ex_mem_write},
          {29'h0, ex_m.reg_we, ex_m.mem_read, ex_m.mem_write});
    check("nop_reg", 32'(o_nop_reg), 32'(nop_m));
  endtask

  task automatic check_comb();
    check("inm_i", 32'(o_inm_i), {16'h0, i_ir[15:0]});
    check("inm_j", 32'(o_inm_j), {6'h0, i_ir[25:0]});
    check("rs", o_rs, e_rs);
    check("hazard", 32'(o_hazard), 32'(e_hazard));
    check("fetch_ctl", {29'h0, o_jump_inm, o_jump_rs, o_branch}, {29'h0, e_jinm, e_jrs, e_br});
  endtask

  // Entered and left at posedge+1; checks at the falling edge, model advances on the rising edge.
  task automatic step(input logic [31:0] ir, input logic [31:0] pc, input logic valid,
                      input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic mwe, input logic [4:0] mwa);
    i_ir = ir; i_pc = pc; i_valid = valid;
    i_wb_we = wbwe; i_wb_addr = wba; i_wb_data = wbd;
    i_mem_reg_we = mwe; i_mem_wb_addr = mwa;
    @(negedge i_clock);
    model_eval();
    check_regs();
    check_comb();
    ob_hazard = o_hazard; ob_branch = o_branch; ob_jinm = o_jump_inm; ob_jrs = o_jump_rs;
    ob_rs = o_rs; ob_inm_i = 32'(o_inm_i);
    @(posedge i_clock);
    model_commit();
    #1;
  endtask

  task automatic issue(input logic [31:0] ir);
    step(ir, tb_pc, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tb_pc += 4;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    step(32'h0, tb_pc, 1'b1, 1'b1, a, d, 1'b0, 5'd0);
  endtask

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, rs, rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic hold_reset();
    i_reset = 1'b0; i_valid = 1'b0; i_wb_we = 1'b0; i_mem_reg_we = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
  endtask

  int ops [16] = '{0, 0, 0, 2, 3, 4, 5, 4, 8, 9, 12, 13, 14, 15, 35, 43};
  int fns [6]  = '{32, 34, 8, 9, 0, 37};

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_ir = '0; i_pc = '0;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_mem_reg_we = 1'b0; i_mem_wb_addr = '0;
    #12;
    hold_reset();

    // taken BEQ, delay-slot squash
    wb_write(5'd3, 32'd7);
    wb_write(5'd4, 32'd7);
    issue(itype(4, 3, 4, 16'd5));
    check("beq_taken", 32'(ob_branch), 32'd1);
    check("beq_inm_i", ob_inm_i, 32'd5);
    check("beq_nop_reg", 32'(o_nop_reg), 32'd1);
    issue(rtype(3, 4, 5, 0, 32));
    check("slot_bubble", 32'(o_ex_reg_we), 32'd0);
    check("slot_nop_clr", 32'(o_nop_reg), 32'd0);

    // load-use stall
    issue(itype(35, 1, 2, 16'h0));
    issue(rtype(2, 3, 5, 0, 32));
    check("lu_hazard", 32'(ob_hazard), 32'd1);
    check("lu_bubble", 32'(o_ex_reg_we), 32'd0);
    step(rtype(2, 3, 5, 0, 32), tb_pc, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    check("lu_release", 32'(ob_hazard), 32'd0);
    check("lu_add_dst", 32'(o_ex_wb_addr), 32'd5);

    // immediates
    issue(itype(8, 0, 6, 16'hFFFF));
    check("addi_sext", o_ex_inm, 32'hFFFF_FFFF);
    issue(itype(13, 0, 6, 16'hFFFF));
    check("ori_zext", o_ex_inm, 32'h0000_FFFF);

    // JAL then JR $31 waiting on the link write
    step({6'd3, 26'h100}, 32'h40, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("jal_jump", 32'(ob_jinm), 32'd1);
    check("jal_dst", 32'(o_ex_wb_addr), 32'd31);
    check("jal_pc", o_ex_pc, 32'h40);
    step(rtype(31, 0, 0, 0, 8), 32'h44, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("jr_ex_hz", 32'(ob_hazard), 32'd1);
    step(rtype(31, 0, 0, 0, 8), 32'h44, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31);
    check("jr_mem_hz", 32'(ob_hazard), 32'd1);
    step(rtype(31, 0, 0, 0, 8), 32'h44, 1'b1, 1'b1, 5'd31, 32'h44, 1'b0, 5'd0);
`ifdef ID_REGFILE_BYPASS_EN
    check("jr_wb_hz", 32'(ob_hazard), 32'd0);
`else
    check("jr_wb_hz", 32'(ob_hazard), 32'd1);
    step(rtype(31, 0, 0, 0, 8), 32'h44, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("jr_clear_hz", 32'(ob_hazard), 32'd0);
`endif
    check("jr_taken", 32'(ob_jrs), 32'd1);
    check("jr_target", ob_rs, 32'h44);
    issue(32'h0);
    issue(32'h0);

    // write-back collision on a read register
    step(rtype(9, 0, 10, 0, 32), tb_pc, 1'b1, 1'b1, 5'd9, 32'hAB, 1'b0, 5'd0);
`ifdef ID_REGFILE_BYPASS_EN
    check("wb_col_hz", 32'(ob_hazard), 32'd0);
`else
    check("wb_col_hz", 32'(ob_hazard), 32'd1);
    issue(rtype(9, 0, 10, 0, 32));
    check("wb_col_rel", 32'(ob_hazard), 32'd0);
`endif
    check("wb_col_data", o_ex_rs_data, 32'hAB);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int op, fn;
      logic [31:0] ir, d;
      op = ops[$urandom_range(15)];
      fn = fns[$urandom_range(5)];
      if (op == 0)
        ir = rtype($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(31), fn);
      else if (op == 2 || op == 3)
        ir = {6'(op), 26'($urandom)};
      else
        ir = itype(op, $urandom_range(7), $urandom_range(7), 16'($urandom));
      case ($urandom_range(3))
        0: d = 32'd7;
        1: d = 32'd0;
        2: d = 32'($urandom_range(3));
        default: d = $urandom;
      endcase
      step(ir, $urandom, ($urandom_range(9) != 0), ($urandom_range(1) == 1),
           5'($urandom_range(7)), d, ($urandom_range(1) == 1), 5'($urandom_range(7)));
    end

    // asynchronous reset in the middle of a load-use stall
    step(32'h0, tb_pc, 1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0);
    issue(itype(35, 1, 2, 16'h4));
    i_ir = rtype(2, 3, 8, 0, 32); i_valid = 1'b1; i_wb_we = 1'b0; i_mem_reg_we = 1'b0;
    @(negedge i_clock);
    #1;
    check("mid_hazard", 32'(o_hazard), 32'd1);
    hold_reset();
    issue(rtype(5, 0, 7, 0, 32));
    check("post_rst_r5", o_ex_rs_data, 32'h0);
    issue(32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
